// File: rtl/alu_seq_pkg.sv
// Shared definitions for the shared-ALU sequencer: opcodes, FSM states and
// the active-low 7-segment lookup for digits 0..7.
package alu_seq_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;
  localparam logic [1:0] OP_SHL = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    HOLD = 2'd2
  } state_t;

  // Index 0 is the rightmost element: SEG_DIGIT[d] is the pattern for digit d.
  localparam logic [7:0][6:0] SEG_DIGIT = {
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

endpackage

// File: rtl/alu_share_seq_seg7.sv
// seg7_dec: combinational 3-bit digit to active-low 7-segment decoder.
module seg7_dec
  import alu_seq_pkg::*;
(
  input  logic [2:0] digit_i,
  output logic [6:0] seg_o
);

  assign seg_o = SEG_DIGIT[digit_i];

endmodule

// File: rtl/alu_share_seq.sv
// alu_share_seq: one 3-bit ALU shared by two requesters under round-robin
// arbitration. The result is held on the HEX displays for HOLD_CYCLES
// cycles after each ack before the next request is accepted.
// Optional build macro ALU_SEQ_CARRY_EN adds a registered carry/borrow
// output and shows it on HEX1; without it HEX1 is a constant "0".
module alu_share_seq
  import alu_seq_pkg::*;
#(
  parameter int HOLD_CYCLES = 4,
  parameter int CNT_W       = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic [1:0] op0,
  input  logic [2:0] a0,
  input  logic [2:0] b0,
  input  logic       req1,
  input  logic [1:0] op1,
  input  logic [2:0] a1,
  input  logic [2:0] b1,
  output logic       ack0,
  output logic       ack1,
  output logic [2:0] result,
  output logic       busy,
`ifdef ALU_SEQ_CARRY_EN
  output logic       carry,
`endif
  output logic [6:0] HEX0,
  output logic [6:0] HEX1
);

  state_t           state_q;
  logic             rr_q;      // 0: requester 0 wins a tie, 1: requester 1 wins
  logic             gnt_q;     // requester currently being served
  logic [1:0]       op_q;
  logic [2:0]       a_q;
  logic [2:0]       b_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       result_q;
  logic [2:0]       result_d;
  logic             ack0_q;
  logic             ack1_q;
  logic             win1;
`ifdef ALU_SEQ_CARRY_EN
  logic             carry_q;
  logic             carry_d;
`endif

  function automatic logic [2:0] alu_res(input logic [1:0] op,
                                         input logic [2:0] a,
                                         input logic [2:0] b);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_XOR:  return a ^ b;
      default: return {a[1:0], 1'b0};
    endcase
  endfunction

`ifdef ALU_SEQ_CARRY_EN
  function automatic logic alu_carry(input logic [1:0] op,
                                     input logic [2:0] a,
                                     input logic [2:0] b);
    case (op)
      OP_ADD:  return (4'(a) + 4'(b)) > 4'd7;
      OP_SUB:  return a < b;
      OP_SHL:  return a[2];
      default: return 1'b0;
    endcase
  endfunction
`endif

  // Requester 1 wins when it is alone, or when both ask and the pointer favours it.
  assign win1 = req1 & (~req0 | rr_q);

  // ALU evaluation on the captured operands.
  always_comb begin
    result_d = alu_res(op_q, a_q, b_q);
`ifdef ALU_SEQ_CARRY_EN
    carry_d  = alu_carry(op_q, a_q, b_q);
`endif
  end

  // Arbitration, execute and display-hold sequencing.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      rr_q     <= 1'b0;
      gnt_q    <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
`ifdef ALU_SEQ_CARRY_EN
      carry_q  <= 1'b0;
`endif
    end else begin
      ack0_q <= 1'b0;
      ack1_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req0 | req1) begin
            if (req0 & req1) rr_q <= ~win1;
            gnt_q   <= win1;
            op_q    <= win1 ? op1 : op0;
            a_q     <= win1 ? a1 : a0;
            b_q     <= win1 ? b1 : b0;
            state_q <= EXEC;
          end
        end
        EXEC: begin
          result_q <= result_d;
`ifdef ALU_SEQ_CARRY_EN
          carry_q  <= carry_d;
`endif
          ack0_q   <= ~gnt_q;
          ack1_q   <= gnt_q;
          cnt_q    <= CNT_W'(HOLD_CYCLES - 1);
          state_q  <= HOLD;
        end
        HOLD: begin
          if (cnt_q == '0) state_q <= IDLE;
          else             cnt_q   <= cnt_q - 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ack0   = ack0_q;
  assign ack1   = ack1_q;
  assign result = result_q;
  assign busy   = (state_q != IDLE);

  seg7_dec u_hex0 (
    .digit_i (result_q),
    .seg_o   (HEX0)
  );

`ifdef ALU_SEQ_CARRY_EN
  assign carry = carry_q;

  seg7_dec u_hex1 (
    .digit_i ({2'b00, carry_q}),
    .seg_o   (HEX1)
  );
`else
  assign HEX1 = SEG_DIGIT[0];
`endif

endmodule

// File: tb/tb_alu_share_seq.sv
// Self-checking bench for alu_share_seq: table-driven single operations plus
// hand-written reset, contention, hold-blocking and early-drop sequences.
module tb_alu_share_seq;

  localparam int H = 4;

  typedef struct packed {
    logic       id;
    logic [1:0] op;
    logic [2:0] a;
    logic [2:0] b;
    logic [2:0] res;
    logic [6:0] hex0;
    logic       cy;
  } vec_t;

  typedef struct packed {
    logic       id;
    logic [2:0] res;
    logic [6:0] hex0;
    logic       cy;
  } exp_t;

  typedef struct {
    int         cyc;
    logic       a0;
    logic       a1;
    logic [2:0] res;
    logic [6:0] h0;
    logic [6:0] h1;
    logic       cy;
  } obs_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0, req1;
  logic [1:0] op0, op1;
  logic [2:0] a0, b0, a1, b1;
  logic       ack0, ack1, busy;
  logic [2:0] result;
  logic [6:0] HEX0, HEX1;
  logic       cy_obs;

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  obs_t obs[64];
  int   obs_n = 0;
  int   rd    = 0;
  exp_t expq[$];
  vec_t vecs[9];

  always #5 clk = ~clk;

  alu_share_seq #(.HOLD_CYCLES(H), .CNT_W(8)) dut (
    .clk    (clk),
    .rst    (rst),
    .req0   (req0),
    .op0    (op0),
    .a0     (a0),
    .b0     (b0),
    .req1   (req1),
    .op1    (op1),
    .a1     (a1),
    .b1     (b1),
    .ack0   (ack0),
    .ack1   (ack1),
    .result (result),
    .busy   (busy),
`ifdef ALU_SEQ_CARRY_EN
    .carry  (cy_obs),
`endif
    .HEX0   (HEX0),
    .HEX1   (HEX1)
  );

`ifndef ALU_SEQ_CARRY_EN
  assign cy_obs = 1'b0;
`endif

  always @(posedge clk) cyc <= cyc + 1;

  // Record every ack cycle for the scoreboard.
  always @(negedge clk) begin
    if ((ack0 || ack1) && obs_n < 64) begin
      obs[obs_n] <= '{cyc, ack0, ack1, result, HEX0, HEX1, cy_obs};
      obs_n      <= obs_n + 1;
    end
  end

  function automatic logic [6:0] exp_hex1(input logic cy);
`ifdef ALU_SEQ_CARRY_EN
    return cy ? 7'b1111001 : 7'b1000000;
`else
    return (cy === 1'bx) ? 7'b0000000 : 7'b1000000;
`endif
  endfunction

  task automatic chk(input string name, input int act, input int expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, expv, expv);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (busy) chk("idle_timeout", int'(busy), 0);
  endtask

  task automatic pop_check(input string name, output int t);
    int   n = 0;
    exp_t e;
    obs_t o;
    t = 0;
    while (obs_n <= rd && n < 30) begin
      @(posedge clk); #1;
      n++;
    end
    if (obs_n <= rd) begin
      chk({name, "_ack_timeout"}, 0, 1);
      if (expq.size() > 0) void'(expq.pop_front());
      return;
    end
    if (expq.size() == 0) begin
      chk({name, "_unexpected_ack"}, 1, 0);
      rd++;
      return;
    end
    e = expq.pop_front();
    o = obs[rd];
    rd++;
    chk({name, "_ackid"}, int'({o.a1, o.a0}), e.id ? 2 : 1);
    chk({name, "_result"}, int'(o.res), int'(e.res));
    chk({name, "_hex0"}, int'(o.h0), int'(e.hex0));
    chk({name, "_hex1"}, int'(o.h1), int'(exp_hex1(e.cy)));
`ifdef ALU_SEQ_CARRY_EN
    chk({name, "_carry"}, int'(o.cy), int'(e.cy));
`endif
    t = o.cyc;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int t0, t1, tp;

    vecs[0] = '{1'b0, 2'b00, 3'd3, 3'd2, 3'd5, 7'b0010010, 1'b0};
    vecs[1] = '{1'b0, 2'b00, 3'd5, 3'd4, 3'd1, 7'b1111001, 1'b1};
    vecs[2] = '{1'b1, 2'b01, 3'd6, 3'd1, 3'd5, 7'b0010010, 1'b0};
    vecs[3] = '{1'b0, 2'b01, 3'd2, 3'd3, 3'd7, 7'b1111000, 1'b1};
    vecs[4] = '{1'b1, 2'b11, 3'd7, 3'd0, 3'd6, 7'b0000010, 1'b1};
    vecs[5] = '{1'b0, 2'b10, 3'd5, 3'd3, 3'd6, 7'b0000010, 1'b0};
    vecs[6] = '{1'b1, 2'b10, 3'd7, 3'd7, 3'd0, 7'b1000000, 1'b0};
    vecs[7] = '{1'b0, 2'b11, 3'd3, 3'd5, 3'd6, 7'b0000010, 1'b0};
    vecs[8] = '{1'b1, 2'b00, 3'd7, 3'd7, 3'd6, 7'b0000010, 1'b1};

    rst = 1'b1;
    req0 = 1'b0; op0 = 2'b00; a0 = 3'd0; b0 = 3'd0;
    req1 = 1'b0; op1 = 2'b00; a1 = 3'd0; b1 = 3'd0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    chk("rst_result", int'(result), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_hex0", int'(HEX0), int'(7'b1000000));
    chk("rst_hex1", int'(HEX1), int'(7'b1000000));
    chk("rst_acks", int'({ack1, ack0}), 0);

    // Reset asserted while the operation is in EXEC must abort it.
    req0 = 1'b1; op0 = 2'b00; a0 = 3'd3; b0 = 3'd2;
    @(posedge clk); #1;
    chk("exec_busy", int'(busy), 1);
    rst = 1'b1; req0 = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b0;
    chk("abort_result", int'(result), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_hex0", int'(HEX0), int'(7'b1000000));
    chk("abort_hex1", int'(HEX1), int'(7'b1000000));
    repeat (4) begin @(posedge clk); #1; end
    chk("abort_no_ack", obs_n, 0);

    // Table of single-requester operations.
    for (int i = 0; i < 9; i++) begin
      wait_idle();
      expq.push_back('{vecs[i].id, vecs[i].res, vecs[i].hex0, vecs[i].cy});
      t0 = cyc;
      if (vecs[i].id) begin
        req1 = 1'b1; op1 = vecs[i].op; a1 = vecs[i].a; b1 = vecs[i].b;
      end else begin
        req0 = 1'b1; op0 = vecs[i].op; a0 = vecs[i].a; b0 = vecs[i].b;
      end
      pop_check($sformatf("vec%0d", i), t1);
      chk($sformatf("vec%0d_latency", i), t1 - t0, 2);
      req0 = 1'b0; req1 = 1'b0;
    end
    wait_idle();
    chk("idle_keeps_hex0", int'(HEX0), int'(vecs[8].hex0));
    chk("idle_keeps_result", int'(result), int'(vecs[8].res));

    // Contention: both held, grants must alternate starting with requester 0.
    for (int i = 0; i < 2; i++) begin
      expq.push_back('{1'b0, 3'd7, 7'b1111000, 1'b1});
      expq.push_back('{1'b1, 3'd5, 7'b0010010, 1'b0});
    end
    req0 = 1'b1; op0 = 2'b01; a0 = 3'd2; b0 = 3'd3;
    req1 = 1'b1; op1 = 2'b01; a1 = 3'd6; b1 = 3'd1;
    tp = 0;
    for (int i = 0; i < 4; i++) begin
      pop_check($sformatf("cont%0d", i), t1);
      if (i > 0) chk($sformatf("cont%0d_spacing", i), t1 - tp, 2 + H);
      tp = t1;
    end
    req0 = 1'b0; req1 = 1'b0;

    // Request from requester 1 arriving during HOLD waits for HOLD to expire.
    wait_idle();
    expq.push_back('{1'b0, 3'd3, 7'b0110000, 1'b0});
    req0 = 1'b1; op0 = 2'b00; a0 = 3'd1; b0 = 3'd2;
    pop_check("hold_first", t1);
    req0 = 1'b0;
    expq.push_back('{1'b1, 3'd5, 7'b0010010, 1'b0});
    req1 = 1'b1; op1 = 2'b10; a1 = 3'd4; b1 = 3'd1;
    chk("hold_busy", int'(busy), 1);
    pop_check("hold_second", tp);
    chk("hold_spacing", tp - t1, 2 + H);
    req1 = 1'b0;

    // One-cycle request pulse; operands changed right after grant.
    wait_idle();
    expq.push_back('{1'b0, 3'd2, 7'b0100100, 1'b0});
    req0 = 1'b1; op0 = 2'b00; a0 = 3'd1; b0 = 3'd1;
    t0 = cyc;
    @(posedge clk); #1;
    req0 = 1'b0; op0 = 2'b01; a0 = 3'd7; b0 = 3'd7;
    pop_check("early_drop", t1);
    chk("early_drop_latency", t1 - t0, 2);

    repeat (12) begin @(posedge clk); #1; end
    chk("no_extra_acks", obs_n, rd);
    chk("final_busy", int'(busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
